vga_dither_packer: RTL and testbench

- Parametrised successor to the raytracer's TinyTapeout output stage: takes full-depth RGB plus timing from the VGA core and reduces each channel from IN_W to OUT_W bits.
- Reduction modes: truncation, 4x4 ordered (Bayer) dither, temporal dither, or a built-in colour-bar test pattern.
- Timing signals are pipelined to stay aligned with colour; output is also packed into the TinyTapeout 8-bit pin order.
- Sits between vga_raytracer and the top-level tt_um_* wrapper.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_chan_reduce.sv | 31 +++
 rtl/vga_dither_packer.sv | 163 ++++++++++++++++
 tb/tb_vga_dither_packer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA output stage: reduction modes,
// the 4x4 ordered-dither matrix and TinyTapeout pin positions.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC    = 2'd0,
    MODE_ORDERED  = 2'd1,
    MODE_TEMPORAL = 2'd2,
    MODE_BARS     = 2'd3
  } mode_e;

  // Row-major, entry [y*4 + x].
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  localparam int TT_R1 = 0;
  localparam int TT_G1 = 1;
  localparam int TT_B1 = 2;
  localparam int TT_VS = 3;
  localparam int TT_R0 = 4;
  localparam int TT_G0 = 5;
  localparam int TT_B0 = 6;
  localparam int TT_HS = 7;

  function automatic logic [3:0] bayer_at(input logic [1:0] x, input logic [1:0] y);
    return BAYER[{y, x}];
  endfunction

endpackage

// File: rtl/vga_chan_reduce.sv
// One colour channel: optional threshold add with saturation, then keep
// the top OUT_W bits.
module vga_chan_reduce
  import vga_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2
) (
  input  logic [IN_W-1:0]  c_i,
  input  logic [3:0]       t_i,
  input  mode_e            mode_i,
  output logic [OUT_W-1:0] c_o
);

  localparam int SH = IN_W - OUT_W - 4;

  logic [IN_W:0]   add;
  logic [IN_W:0]   sum;
  logic [IN_W-1:0] sat;
  logic            dith;

  always_comb begin
    // Max offset stays below one output LSB, so zero never rounds up.
    add  = {{(IN_W-3){1'b0}}, t_i} << SH;
    sum  = {1'b0, c_i} + add;
    sat  = sum[IN_W] ? {IN_W{1'b1}} : sum[IN_W-1:0];
    dith = (mode_i == MODE_ORDERED) || (mode_i == MODE_TEMPORAL);
    c_o  = dith ? sat[IN_W-1 -: OUT_W] : c_i[IN_W-1 -: OUT_W];
  end

endmodule

// File: rtl/vga_dither_packer.sv
// VGA output stage: 2-cycle pipeline reducing IN_W-bit RGB to OUT_W bits by
// truncation / ordered / temporal dither or colour bars, with aligned sync.
module vga_dither_packer
  import vga_pkg::*;
#(
  parameter int   IN_W         = 8,
  parameter int   OUT_W        = 2,
  parameter int   COORD_W      = 10,
  parameter logic HSYNC_ACTIVE = 1'b0,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   BAR_SHIFT    = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               visible_in,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [IN_W-1:0]    red_in,
  input  logic [IN_W-1:0]    green_in,
  input  logic [IN_W-1:0]    blue_in,
  output logic [OUT_W-1:0]   red_out,
  output logic [OUT_W-1:0]   green_out,
  output logic [OUT_W-1:0]   blue_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               visible_out,
  output logic [7:0]         tt_out,
  output logic [1:0]         mode_active,
  output logic [1:0]         frame_count
);

  if (IN_W - OUT_W < 4) begin : g_bad_width
    $error("vga_dither_packer: IN_W - OUT_W must be at least 4");
  end

  localparam int NCH = 3;

  // Frame-level state
  logic  vs_prev_q;
  mode_e mode_q;
  logic [1:0] fcnt_q;
  logic  frame_evt;

  // Stage 1
  logic [NCH-1:0][IN_W-1:0] rgb_in;
  logic [NCH-1:0][IN_W-1:0] c_d, c_q;
  logic [3:0]               t_d, t_q;
  mode_e                    mode_s1_q;
  logic [1:0]               tx, ty;
  logic [COORD_W-1:0]       bar_x;

  // Stage 2
  logic [NCH-1:0][OUT_W-1:0] red_c;
  logic [NCH-1:0][OUT_W-1:0] col_d, col_q;

  // Timing delay lines, [1] is the output stage
  logic [1:0] hs_q, vs_q, vis_q;

  assign rgb_in    = {blue_in, green_in, red_in};
  assign frame_evt = (vsync_in == VSYNC_ACTIVE) && (vs_prev_q != VSYNC_ACTIVE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_prev_q <= ~VSYNC_ACTIVE;
      mode_q    <= MODE_TRUNC;
      fcnt_q    <= '0;
    end else begin
      vs_prev_q <= vsync_in;
      // Mode only switches on the frame edge so a frame is never mixed.
      if (frame_evt) begin
        mode_q <= mode_e'(mode_in);
        fcnt_q <= fcnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    tx = x_in[1:0];
    ty = y_in[1:0];
    if (mode_q == MODE_TEMPORAL) begin
      tx = tx + fcnt_q;
      ty = ty + fcnt_q;
    end
    t_d   = bayer_at(tx, ty);
    bar_x = x_in >> BAR_SHIFT;
    for (int i = 0; i < NCH; i++) begin
      c_d[i] = (mode_q == MODE_BARS) ? {IN_W{bar_x[i]}} : rgb_in[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_q       <= '0;
      t_q       <= '0;
      mode_s1_q <= MODE_TRUNC;
    end else begin
      c_q       <= c_d;
      t_q       <= t_d;
      mode_s1_q <= mode_q;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    vga_chan_reduce #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_red (
      .c_i    (c_q[i]),
      .t_i    (t_q),
      .mode_i (mode_s1_q),
      .c_o    (red_c[i])
    );
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      col_d[i] = vis_q[0] ? red_c[i] : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      hs_q  <= {2{~HSYNC_ACTIVE}};
      vs_q  <= {2{~VSYNC_ACTIVE}};
      vis_q <= '0;
    end else begin
      col_q <= col_d;
      hs_q  <= {hs_q[0], hsync_in};
      vs_q  <= {vs_q[0], vsync_in};
      vis_q <= {vis_q[0], visible_in};
    end
  end

  assign red_out     = col_q[0];
  assign green_out   = col_q[1];
  assign blue_out    = col_q[2];
  assign hsync_out   = hs_q[1];
  assign vsync_out   = vs_q[1];
  assign visible_out = vis_q[1];
  assign mode_active = mode_q;
  assign frame_count = fcnt_q;

  if (OUT_W == 2) begin : g_tt
    always_comb begin
      tt_out        = '0;
      tt_out[TT_HS] = hs_q[1];
      tt_out[TT_VS] = vs_q[1];
      tt_out[TT_R0] = col_q[0][0];
      tt_out[TT_G0] = col_q[1][0];
      tt_out[TT_B0] = col_q[2][0];
      tt_out[TT_R1] = col_q[0][1];
      tt_out[TT_G1] = col_q[1][1];
      tt_out[TT_B1] = col_q[2][1];
    end
  end else begin : g_no_tt
    assign tt_out = '0;
  end

endmodule

// File: tb/tb_vga_dither_packer.sv
// Scoreboard bench for vga_dither_packer with default parameters (8->2 bits).
module tb_vga_dither_packer;

  logic       clock = 0;
  logic       reset;
  logic [1:0] mode_in;
  logic       hsync_in, vsync_in, visible_in;
  logic [9:0] x_in, y_in;
  logic [7:0] red_in, green_in, blue_in;
  logic [1:0] red_out, green_out, blue_out;
  logic       hsync_out, vsync_out, visible_out;
  logic [7:0] tt_out;
  logic [1:0] mode_active, frame_count;

  vga_dither_packer dut (
    .clock(clock), .reset(reset), .mode_in(mode_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .visible_in(visible_in),
    .x_in(x_in), .y_in(y_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .visible_out(visible_out),
    .tt_out(tt_out), .mode_active(mode_active), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] r, g, b;
    logic       hs, vs, vis;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bay[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  logic [1:0] m_mode, m_fc;
  logic       m_vsp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] mred(input logic [7:0] c, input int t, input logic [1:0] m,
                                      input logic barbit);
    int s;
    case (m)
      2'd0: return c[7:6];
      2'd3: return barbit ? 2'd3 : 2'd0;
      default: begin
        s = int'(c) + t * 4;
        if (s > 255) s = 255;
        return 2'(s / 64);
      end
    endcase
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, "_rgb"}, {red_out, green_out, blue_out}, 6'd0);
    chk({tag, "_sync"}, {hsync_out, vsync_out, visible_out}, 3'b110);
    chk({tag, "_tt"}, tt_out, 8'h88);
    chk({tag, "_mode"}, {mode_active, frame_count}, 4'd0);
  endtask

  task automatic step();
    exp_t e;
    int tx, ty, t, bar;
    logic [7:0] tt;
    tx = int'(x_in[1:0]);
    ty = int'(y_in[1:0]);
    if (m_mode == 2'd2) begin
      tx = (tx + int'(m_fc)) % 4;
      ty = (ty + int'(m_fc)) % 4;
    end
    t   = bay[ty][tx];
    bar = (int'(x_in) >> 7) & 7;
    e.r   = visible_in ? mred(red_in,   t, m_mode, bar[0]) : 2'd0;
    e.g   = visible_in ? mred(green_in, t, m_mode, bar[1]) : 2'd0;
    e.b   = visible_in ? mred(blue_in,  t, m_mode, bar[2]) : 2'd0;
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.vis = visible_in;
    q.push_back(e);
    if (vsync_in == 1'b0 && m_vsp == 1'b1) begin
      m_mode = mode_in;
      m_fc   = m_fc + 2'd1;
    end
    m_vsp = vsync_in;
    @(posedge clock);
    #1;
    chk("mode_active", mode_active, m_mode);
    chk("frame_count", frame_count, m_fc);
    if (q.size() >= 2) begin
      e  = q.pop_front();
      tt = {e.hs, e.b[0], e.g[0], e.r[0], e.vs, e.b[1], e.g[1], e.r[1]};
      chk("red", red_out, e.r);
      chk("green", green_out, e.g);
      chk("blue", blue_out, e.b);
      chk("sync", {hsync_out, vsync_out, visible_out}, {e.hs, e.vs, e.vis});
      chk("tt_out", tt_out, tt);
    end
  endtask

  task automatic px(input logic [1:0] m, input logic hs, input logic vs, input logic vis,
                    input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                    input logic [7:0] b);
    mode_in = m; hsync_in = hs; vsync_in = vs; visible_in = vis;
    x_in = 10'(x); y_in = 10'(y);
    red_in = r; green_in = g; blue_in = b;
    step();
  endtask

  task automatic vpulse(input logic [1:0] m);
    px(m, 1, 0, 0, 0, 0, 0, 0, 0);
    px(m, 1, 0, 0, 0, 0, 0, 0, 0);
    px(m, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 2'd0;
    m_fc   = 2'd0;
    m_vsp  = 1'b1;
  endtask

  initial begin
    reset = 1;
    mode_in = 0; hsync_in = 1; vsync_in = 1; visible_in = 0;
    x_in = 0; y_in = 0; red_in = 0; green_in = 0; blue_in = 0;
    model_reset();
    // Reset held with inputs toggling
    for (int i = 0; i < 3; i++) begin
      mode_in = 2'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      visible_in = 1; red_in = 8'($urandom); green_in = 8'($urandom); blue_in = 8'($urandom);
      x_in = 10'($urandom); y_in = 10'($urandom);
      @(posedge clock);
      #1;
      chk_rst("reset");
    end
    px(0, 1, 1, 0, 0, 0, 0, 0, 0);
    reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) px(0, 1, 1, 0, 0, 0, 0, 0, 0);
    px(0, 0, 1, 0, 0, 0, 0, 0, 0);
    px(0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Truncate, visible and blanked
    px(0, 1, 1, 1, 5, 3, 8'hBF, 8'h40, 8'hFF);
    px(0, 1, 1, 1, 6, 3, 8'h7F, 8'hC0, 8'h00);
    px(0, 1, 1, 0, 7, 3, 8'hBF, 8'hFF, 8'hFF);

    // Mode request mid-frame held off until the vsync edge
    for (int i = 0; i < 3; i++) px(1, 1, 1, 1, i, 0, 8'h70, 8'h70, 8'h70);
    vpulse(1);

    // Ordered dither scan over the 4x4 cell
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        px(1, 1, 1, 1, x + 8, y + 4, 8'h70, 8'hFF, 8'h00);
    for (int i = 0; i < 8; i++)
      px(1, 1, 1, 1, i, i + 1, 8'($urandom), 8'($urandom), 8'($urandom));

    // Frame counter wrap
    for (int f = 0; f < 4; f++) begin
      vpulse(1);
      px(1, 1, 1, 1, 1, 2, 8'h70, 8'h30, 8'hC4);
    end

    // Temporal dither at a fixed pixel over several frames
    vpulse(2);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 2; i++) px(2, 1, 1, 1, 0, 0, 8'h70, 8'hB4, 8'h3C);
      px(2, 1, 1, 1, 1, 3, 8'h70, 8'hB4, 8'h3C);
      vpulse(2);
    end

    // Colour bars
    vpulse(3);
    for (int i = 0; i < 8; i++) px(3, 1, 1, 1, i * 128, 7, 8'h55, 8'hAA, 8'h12);
    px(3, 1, 1, 0, 384, 7, 8'hFF, 8'hFF, 8'hFF);

    // Random traffic with occasional frame edges
    for (int i = 0; i < 200; i++)
      px(2'($urandom), 1'($urandom), ($urandom_range(0, 15) != 0), 1'($urandom),
         int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
         8'($urandom), 8'($urandom), 8'($urandom));

    // Asynchronous reset mid-frame
    px(mode_in, 0, 1, 1, 3, 3, 8'hFF, 8'hFF, 8'hFF);
    reset = 1;
    #1;
    chk_rst("async_reset");
    @(posedge clock);
    #1;
    chk_rst("async_hold");
    mode_in = 0; hsync_in = 0; vsync_in = 1; visible_in = 1;
    x_in = 0; y_in = 0; red_in = 8'hC0; green_in = 8'h80; blue_in = 8'h40;
    reset = 0;
    model_reset();
    for (int i = 0; i < 4; i++) px(0, 1'(i), 1, 1, i, 0, 8'hC0, 8'h80, 8'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
